axi_burst_slave_ram: RTL and testbench

//  AXI4 slave endpoint. Sits on an interconnect slave port (s0..s3) and services master bursts into a word-addressed RAM.

---
 rtl/axi_pkg.sv | 31 +++
 rtl/axi_addr_gen.sv | 30 +++
 rtl/axi_burst_slave_ram.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_burst_slave_ram.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the burst slave RAM: burst and response encodings,
// FSM state types, and the burst legality check used by both channels.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // A burst is illegal when it is wider than the bus, uses the reserved
  // burst type, or is a WRAP whose beat count is not 2, 4, 8 or 16.
  function automatic logic burstCfgErr(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [2:0] maxSize);
    logic err;
    err = (size > maxSize) || (burst == 2'b11);
    if ((burst == BURST_WRAP) &&
        !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)))
      err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_nextAddr
);

  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_wrapMask;

  assign w_step     = ADDR_W'(1) << i_size;
  assign w_wrapMask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);

  // Select the address step rule for the burst type; reserved type holds address.
  always_comb begin
    o_nextAddr = i_addr;
    case (i_burst)
      BURST_INCR: o_nextAddr = (i_addr & ~(w_step - ADDR_W'(1))) + w_step;
      BURST_WRAP: o_nextAddr = (i_addr & ~w_wrapMask) | ((i_addr + w_step) & w_wrapMask);
      default:    o_nextAddr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_slave_ram.sv
// AXI4 burst slave in front of a word-addressed RAM. Independent write and
// read FSMs, one outstanding transaction each. Define AXI_SLV_OOR_ERR_EN to
// answer SLVERR for beats beyond MEM_DEPTH instead of aliasing the address.
module axi_burst_slave_ram
  import axi_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         ADDR_LSB = $clog2(STRB_W);
  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // Write channel state
  w_state_t          r_wState, w_wStateNext;
  logic [ID_W-1:0]   r_awId;
  logic [ADDR_W-1:0] r_awAddr, w_wNextAddr;
  logic [7:0]        r_awLen, r_wBeat;
  logic [2:0]        r_awSize;
  logic [1:0]        r_awBurst, r_bresp;
  logic              r_wCfgErr, r_wRespErr, r_awready, r_bvalid;
  logic              w_awHs, w_wHs, w_wLastBeat, w_wBeatErr, w_wOor, w_wWrEn;
  logic [IDX_W-1:0]  w_wIdx;

  // Read channel state
  r_state_t          r_rState, w_rStateNext;
  logic [ID_W-1:0]   r_arId;
  logic [ADDR_W-1:0] r_arAddr, w_rNextAddr, w_rLoadAddr;
  logic [7:0]        r_arLen, r_rBeat;
  logic [2:0]        r_arSize;
  logic [1:0]        r_arBurst, r_rresp;
  logic              r_arCfgErr, r_arready, r_rvalid, r_rlast;
  logic [DATA_W-1:0] r_rdata, w_rMemWord;
  logic              w_arHs, w_rHs, w_rAdvance, w_rLoad, w_rLoadErr, w_rLoadOor, w_rLoadLast;
  logic [IDX_W-1:0]  w_rLoadIdx;

  axi_addr_gen #(.ADDR_W(ADDR_W)) u_wAddrGen (
    .i_addr(r_awAddr), .i_len(r_awLen), .i_size(r_awSize), .i_burst(r_awBurst),
    .o_nextAddr(w_wNextAddr)
  );

  axi_addr_gen #(.ADDR_W(ADDR_W)) u_rAddrGen (
    .i_addr(r_arAddr), .i_len(r_arLen), .i_size(r_arSize), .i_burst(r_arBurst),
    .o_nextAddr(w_rNextAddr)
  );

`ifdef AXI_SLV_OOR_ERR_EN
  assign w_wOor     = |r_awAddr[ADDR_W-1:ADDR_LSB+IDX_W];
  assign w_rLoadOor = |w_rLoadAddr[ADDR_W-1:ADDR_LSB+IDX_W];
`else
  assign w_wOor     = 1'b0;
  assign w_rLoadOor = 1'b0;
`endif

  assign w_awHs      = s_axi_awvalid & r_awready;
  assign w_wHs       = s_axi_wvalid & (r_wState == W_DATA);
  assign w_wLastBeat = (r_wBeat == r_awLen);
  assign w_wBeatErr  = (s_axi_wlast != w_wLastBeat) | w_wOor;
  assign w_wWrEn     = w_wHs & ~r_wCfgErr & ~w_wOor;
  assign w_wIdx      = r_awAddr[ADDR_LSB +: IDX_W];

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = (r_wState == W_DATA);
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_awId;

  // Write FSM next state: address, data beats, then hold response until accepted.
  always_comb begin
    w_wStateNext = r_wState;
    case (r_wState)
      W_IDLE:  if (w_awHs) w_wStateNext = W_DATA;
      W_DATA:  if (w_wHs && w_wLastBeat) w_wStateNext = W_RESP;
      W_RESP:  if (r_bvalid && s_axi_bready) w_wStateNext = W_IDLE;
      default: w_wStateNext = W_IDLE;
    endcase
  end

  // Write state register plus the registered AWREADY/BVALID derived from it.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_wState  <= W_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wState  <= w_wStateNext;
      r_awready <= (w_wStateNext == W_IDLE);
      r_bvalid  <= (w_wStateNext == W_RESP);
    end
  end

  // Write datapath: latch the burst, step the address, accumulate error status.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_awId     <= '0;
      r_awAddr   <= '0;
      r_awLen    <= '0;
      r_awSize   <= '0;
      r_awBurst  <= '0;
      r_wBeat    <= '0;
      r_wCfgErr  <= 1'b0;
      r_wRespErr <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else if (w_awHs) begin
      r_awId     <= s_axi_awid;
      r_awAddr   <= s_axi_awaddr;
      r_awLen    <= s_axi_awlen;
      r_awSize   <= s_axi_awsize;
      r_awBurst  <= s_axi_awburst;
      r_wBeat    <= 8'd0;
      r_wCfgErr  <= burstCfgErr(s_axi_awlen, s_axi_awsize, s_axi_awburst, MAX_SIZE);
      r_wRespErr <= 1'b0;
    end else if (w_wHs) begin
      r_awAddr <= w_wNextAddr;
      r_wBeat  <= r_wBeat + 8'd1;
      if (w_wBeatErr) r_wRespErr <= 1'b1;
      if (w_wLastBeat)
        r_bresp <= (r_wCfgErr | r_wRespErr | w_wBeatErr) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge s_aclk) begin
    if (w_wWrEn) begin
      for (int i = 0; i < STRB_W; i++)
        if (s_axi_wstrb[i]) r_mem[w_wIdx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
    end
  end

  assign w_arHs     = s_axi_arvalid & r_arready;
  assign w_rHs      = r_rvalid & s_axi_rready;
  assign w_rAdvance = w_rHs & ~r_rlast;
  assign w_rLoad    = w_arHs | w_rAdvance;
  assign w_rLoadIdx = w_rLoadAddr[ADDR_LSB +: IDX_W];
  assign w_rMemWord = r_mem[w_rLoadIdx];

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rid     = r_arId;

  // Pick the beat to fetch next: the AR address on a new burst, else the stepped address.
  always_comb begin
    w_rLoadAddr = w_rNextAddr;
    w_rLoadErr  = r_arCfgErr;
    w_rLoadLast = ((r_rBeat + 8'd1) == r_arLen);
    if (w_arHs) begin
      w_rLoadAddr = s_axi_araddr;
      w_rLoadErr  = burstCfgErr(s_axi_arlen, s_axi_arsize, s_axi_arburst, MAX_SIZE);
      w_rLoadLast = (s_axi_arlen == 8'd0);
    end
  end

  // Read FSM next state: leave R_DATA once the last beat is accepted.
  always_comb begin
    w_rStateNext = r_rState;
    case (r_rState)
      R_IDLE:  if (w_arHs) w_rStateNext = R_DATA;
      R_DATA:  if (w_rHs && r_rlast) w_rStateNext = R_IDLE;
      default: w_rStateNext = R_IDLE;
    endcase
  end

  // Read state register plus the registered ARREADY/RVALID derived from it.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_rState  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rState  <= w_rStateNext;
      r_arready <= (w_rStateNext == R_IDLE);
      r_rvalid  <= (w_rStateNext == R_DATA);
    end
  end

  // Read datapath: fetch a beat on each load, holding outputs while stalled.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_arId     <= '0;
      r_arAddr   <= '0;
      r_arLen    <= '0;
      r_arSize   <= '0;
      r_arBurst  <= '0;
      r_rBeat    <= '0;
      r_arCfgErr <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      if (w_arHs) begin
        r_arId     <= s_axi_arid;
        r_arLen    <= s_axi_arlen;
        r_arSize   <= s_axi_arsize;
        r_arBurst  <= s_axi_arburst;
        r_arCfgErr <= w_rLoadErr;
        r_rBeat    <= 8'd0;
      end else if (w_rAdvance) begin
        r_rBeat <= r_rBeat + 8'd1;
      end
      if (w_rLoad) begin
        r_arAddr <= w_rLoadAddr;
        r_rlast  <= w_rLoadLast;
        if (w_rLoadErr || w_rLoadOor) begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end else begin
          r_rdata <= w_rMemWord;
          r_rresp <= RESP_OKAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_slave_ram.sv
// Directed self-checking bench for axi_burst_slave_ram. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
module tb_axi_burst_slave_ram;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] wBuf [16];
  logic [31:0] eBuf [16];
  logic [31:0] rData [16];
  logic [1:0]  rResp [16];
  logic        rLastSeen [16];
  logic [3:0]  rIdSeen [16];
  int          rCount;
  logic        rFirstValid;
  int          rStallViol;
  int          bHoldViol;
  logic [1:0]  bRespGot;
  logic [3:0]  bIdGot;

  always #5 clk = ~clk;

  axi_burst_slave_ram dut (
    .s_aclk(clk), .s_aresetn(rstN),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic reportTimeout(input string tag);
    checks++;
    failures++;
    $display("[TB] FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // Full write burst: AW, all W beats, then B with optional random BREADY.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                               input int earlyBeat, input bit randBready);
    int n;
    bit done;
    logic prevStall;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) reportTimeout("aw_handshake");
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wBuf[i]; wstrb = strb; wvalid = 1'b1;
      wlast = (earlyBeat >= 0) ? (i == earlyBeat) : (i == int'(len));
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) reportTimeout("w_handshake");
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    done = 1'b0; prevStall = 1'b0; n = 0;
    while (!done && n < 200) begin
      if (prevStall && !bvalid) bHoldViol++;
      bready = randBready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bvalid && bready) begin bRespGot = bresp; bIdGot = bid; done = 1'b1; end
      prevStall = bvalid && !bready;
      @(negedge clk);
      n++;
    end
    bready = 1'b0;
    if (!done) reportTimeout("b_response");
  endtask

  // Full read burst with optional random RREADY; records every accepted beat.
  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit randRready);
    int n;
    bit done;
    logic prevStall, prevLast;
    logic [31:0] prevData;
    logic [1:0] prevResp;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) reportTimeout("ar_handshake");
    @(negedge clk);
    arvalid = 1'b0;
    rFirstValid = rvalid;
    rCount = 0; done = 1'b0; prevStall = 1'b0; n = 0;
    prevData = '0; prevLast = 1'b0; prevResp = '0;
    while (!done && n < 300) begin
      if (prevStall && (!rvalid || rdata !== prevData || rlast !== prevLast || rresp !== prevResp))
        rStallViol++;
      rready = randRready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid && rready) begin
        if (rCount < 16) begin
          rData[rCount] = rdata; rResp[rCount] = rresp;
          rLastSeen[rCount] = rlast; rIdSeen[rCount] = rid;
        end
        rCount++;
        if (rlast) done = 1'b1;
      end
      prevStall = rvalid && !rready;
      prevData = rdata; prevLast = rlast; prevResp = rresp;
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    if (!done) reportTimeout("r_last");
  endtask

  // Compare recorded beats against eBuf, RLAST placement, response and ID.
  task automatic verifyRead(input string tag, input int nBeats, input logic [1:0] expResp, input logic [3:0] expId);
    checkOutput($sformatf("%s_count", tag), 64'(rCount), 64'(nBeats));
    for (int i = 0; i < nBeats && i < rCount && i < 16; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), 64'(rData[i]), 64'(eBuf[i]));
      checkOutput($sformatf("%s_last%0d", tag, i), 64'(rLastSeen[i]), 64'(i == nBeats - 1));
      checkOutput($sformatf("%s_resp%0d", tag, i), 64'(rResp[i]), 64'(expResp));
    end
    if (rCount > 0) checkOutput($sformatf("%s_rid", tag), 64'(rIdSeen[0]), 64'(expId));
  endtask

  initial begin
    rstN = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    rStallViol = 0; bHoldViol = 0;

    // Reset values and the ready rise one clock after release.
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", 64'(awready), 64'd0);
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_wready",  64'(wready),  64'd0);
    checkOutput("rst_bvalid",  64'(bvalid),  64'd0);
    checkOutput("rst_rvalid",  64'(rvalid),  64'd0);
    checkOutput("rst_rdata",   64'(rdata),   64'd0);
    rstN = 1'b1;
    #1 checkOutput("rel_awready_pre", 64'(awready), 64'd0);
    @(negedge clk);
    checkOutput("rel_awready", 64'(awready), 64'd1);
    checkOutput("rel_arready", 64'(arready), 64'd1);

    // INCR write/readback with ID echo.
    for (int i = 0; i < 4; i++) begin wBuf[i] = 32'hA0 + i; eBuf[i] = 32'hA0 + i; end
    applyStimulus(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 4'hF, -1, 1'b0);
    checkOutput("t1_bresp", 64'(bRespGot), 64'd0);
    checkOutput("t1_bid", 64'(bIdGot), 64'h5);
    readBurst(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
    checkOutput("t1_rvalid_latency", 64'(rFirstValid), 64'd1);
    verifyRead("t1", 4, 2'b00, 4'h5);

    // WRAP write from 0x38 lands at 0x38,0x3C,0x30,0x34.
    for (int i = 0; i < 4; i++) wBuf[i] = 32'hB0 + i;
    applyStimulus(4'h3, 32'h38, 8'd3, 3'd2, 2'b10, 4'hF, -1, 1'b0);
    checkOutput("t2_bresp", 64'(bRespGot), 64'd0);
    eBuf[0] = 32'hB2; eBuf[1] = 32'hB3; eBuf[2] = 32'hB0; eBuf[3] = 32'hB1;
    readBurst(4'h3, 32'h30, 8'd3, 3'd2, 2'b01, 1'b0);
    verifyRead("t2_incr", 4, 2'b00, 4'h3);
    for (int i = 0; i < 4; i++) eBuf[i] = 32'hB0 + i;
    readBurst(4'h9, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
    verifyRead("t2_wrap", 4, 2'b00, 4'h9);

    // Byte strobes merge into an existing word.
    wBuf[0] = 32'h11223344;
    applyStimulus(4'h1, 32'h0, 8'd0, 3'd2, 2'b01, 4'hF, -1, 1'b0);
    wBuf[0] = 32'hFFFFFFFF;
    applyStimulus(4'h1, 32'h0, 8'd0, 3'd2, 2'b01, 4'b0101, -1, 1'b0);
    eBuf[0] = 32'h11FF33FF;
    readBurst(4'h2, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    verifyRead("t3", 1, 2'b00, 4'h2);

    // 16-beat INCR under random backpressure on both response channels.
    for (int i = 0; i < 16; i++) begin wBuf[i] = 32'hC0000000 | i; eBuf[i] = 32'hC0000000 | i; end
    applyStimulus(4'hA, 32'h100, 8'd15, 3'd2, 2'b01, 4'hF, -1, 1'b1);
    checkOutput("t4_bresp", 64'(bRespGot), 64'd0);
    checkOutput("t4_bid", 64'(bIdGot), 64'hA);
    readBurst(4'hB, 32'h100, 8'd15, 3'd2, 2'b01, 1'b1);
    verifyRead("t4", 16, 2'b00, 4'hB);
    checkOutput("t4_rdata_stable", 64'(rStallViol), 64'd0);
    checkOutput("t4_bvalid_held", 64'(bHoldViol), 64'd0);

    // Reserved burst type: SLVERR, RAM untouched, reads return zero.
    wBuf[0] = 32'hDEADBEEF;
    applyStimulus(4'h4, 32'h10, 8'd0, 3'd2, 2'b11, 4'hF, -1, 1'b0);
    checkOutput("t5_resv_bresp", 64'(bRespGot), 64'h2);
    eBuf[0] = 32'hA0;
    readBurst(4'h4, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    verifyRead("t5_unchanged", 1, 2'b00, 4'h4);
    eBuf[0] = 32'h0;
    readBurst(4'h4, 32'h10, 8'd0, 3'd2, 2'b11, 1'b0);
    verifyRead("t5_resv_read", 1, 2'b10, 4'h4);

    // Early WLAST: SLVERR but the data is still stored.
    for (int i = 0; i < 4; i++) begin wBuf[i] = 32'hD0 + i; eBuf[i] = 32'hD0 + i; end
    applyStimulus(4'h6, 32'h200, 8'd3, 3'd2, 2'b01, 4'hF, 1, 1'b0);
    checkOutput("t5_wlast_bresp", 64'(bRespGot), 64'h2);
    readBurst(4'h6, 32'h200, 8'd3, 3'd2, 2'b01, 1'b0);
    verifyRead("t5_wlast_data", 4, 2'b00, 4'h6);

    // Address beyond the RAM: error when enabled, otherwise aliases onto word 0.
`ifdef AXI_SLV_OOR_ERR_EN
    eBuf[0] = 32'h0;
    readBurst(4'h7, 32'h10000, 8'd0, 3'd2, 2'b01, 1'b0);
    verifyRead("t5_oor", 1, 2'b10, 4'h7);
`else
    eBuf[0] = 32'h11FF33FF;
    readBurst(4'h7, 32'h10000, 8'd0, 3'd2, 2'b01, 1'b0);
    verifyRead("t5_alias", 1, 2'b00, 4'h7);
`endif

    // Reset in the middle of a stalled read burst, then a clean burst.
    arid = 4'hC; araddr = 32'h100; arlen = 8'd15; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b0;
    begin
      int n;
      n = 0;
      while (!arready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) reportTimeout("t6_ar_handshake");
    end
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("t6_rvalid_before", 64'(rvalid), 64'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t6_rvalid_rst", 64'(rvalid), 64'd0);
    checkOutput("t6_arready_rst", 64'(arready), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1 checkOutput("t6_arready_pre", 64'(arready), 64'd0);
    @(negedge clk);
    checkOutput("t6_arready_post", 64'(arready), 64'd1);
    for (int i = 0; i < 4; i++) eBuf[i] = 32'hA0 + i;
    readBurst(4'hD, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
    verifyRead("t6_after", 4, 2'b00, 4'hD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
